// File: rtl/fm_round_pkg.sv
// Shared definitions for the FP multiplier rounding pipeline.
// Rounding-mode encodings and sticky-flag bit positions.
package fm_round_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RZ  = 3'b001;
    localparam logic [2:0] RM_RP  = 3'b010;
    localparam logic [2:0] RM_RM  = 3'b011;
    localparam logic [2:0] RM_RNA = 3'b100;

    localparam int FLG_DNR = 0;
    localparam int FLG_INX = 1;
    localparam int FLG_UNF = 2;
    localparam int FLG_OVF = 3;

endpackage

// File: rtl/round_decide.sv
// Round-up decision for one significand.
// Unlisted mode encodings fall back to round-to-nearest-even.
module round_decide
    import fm_round_pkg::*;
(
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_sticky,
    input  logic       i_sign,
    input  logic [2:0] i_mode,
    output logic       o_rd
);

    // Select the round-up rule for the active mode
    always_comb begin
        o_rd = 1'b0;
        case (i_mode)
            RM_RZ:   o_rd = 1'b0;
            RM_RP:   o_rd = ~i_sign & (i_guard | i_sticky);
            RM_RM:   o_rd = i_sign & (i_guard | i_sticky);
            RM_RNA:  o_rd = i_guard;
            default: o_rd = i_guard & (i_lsb | i_sticky);
        endcase
    end

endmodule

// File: rtl/round_pipe.sv
// Two-stage valid/ready rounding pipeline for the FP multiplier.
// Stage 1 splits fields and decides rounding; stage 2 finalises.
module round_pipe
    import fm_round_pkg::*;
#(
    parameter int WSIG       = 23,
    parameter int WEXP       = 8,
    parameter int WEXPSUM    = 10,
    parameter int SHIFTWIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHIFTWIDTH-1:0] shiftprod,
    input  logic [WEXPSUM-1:0]    shiftexp,
    input  logic                  shiftloss,
    input  logic [2:0]            roundmode,
    input  logic                  sign,
    input  logic                  tiny,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WSIG-1:0]       roundprod,
    output logic [WEXP-1:0]       roundexp,
    output logic                  inexact,
    output logic                  overflow,
    output logic                  stilltiny,
    output logic                  denormround,
    input  logic                  flag_clr,
    output logic [3:0]            flags_acc
);

    localparam int SW = SHIFTWIDTH;

    // Stage 1 field split
    logic [WSIG-1:0] w_msbits;
    logic            w_lsb;
    logic            w_guard;
    logic            w_sticky;
    logic            w_dsticky;
    logic            w_rd;
    logic [WSIG:0]   w_mp1;

    assign w_msbits  = shiftprod[SW-1:SW-WSIG];
    assign w_lsb     = shiftprod[SW-WSIG];
    assign w_guard   = shiftprod[SW-WSIG-1];
    assign w_sticky  = (|shiftprod[SW-WSIG-2:0]) | shiftloss;
    assign w_dsticky = (|shiftprod[SW-WSIG-3:0]) | shiftloss;
    assign w_mp1     = {1'b0, w_msbits} + {{WSIG{1'b0}}, 1'b1};

    round_decide u_decide (
        .i_lsb    (w_lsb),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .i_sign   (sign),
        .i_mode   (roundmode),
        .o_rd     (w_rd)
    );

    // Stage 1 registers
    logic                r_s1_valid;
    logic [WSIG-1:0]     r_s1_msb;
    logic [WSIG:0]       r_s1_mp1;
    logic                r_s1_guard;
    logic                r_s1_sticky;
    logic                r_s1_dsticky;
    logic                r_s1_rd;
    logic                r_s1_tiny;
    logic [WEXPSUM-1:0]  r_s1_exp;

    // Handshake control
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_hs_in;
    logic w_hs_out;

    assign w_s2_adv  = ~r_s2_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_hs_in   = in_valid & in_ready;
    assign w_hs_out  = r_s2_valid & out_ready;
    assign out_valid = r_s2_valid;

    // Stage 1: capture split fields and round decision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_msb     <= '0;
            r_s1_mp1     <= '0;
            r_s1_guard   <= 1'b0;
            r_s1_sticky  <= 1'b0;
            r_s1_dsticky <= 1'b0;
            r_s1_rd      <= 1'b0;
            r_s1_tiny    <= 1'b0;
            r_s1_exp     <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_msb     <= w_msbits;
                r_s1_mp1     <= w_mp1;
                r_s1_guard   <= w_guard;
                r_s1_sticky  <= w_sticky;
                r_s1_dsticky <= w_dsticky;
                r_s1_rd      <= w_rd;
                r_s1_tiny    <= tiny;
                r_s1_exp     <= shiftexp;
            end
        end
    end

    // Stage 2 combinational finishing
    logic               w_rovf;
    logic [WSIG-1:0]    w_prod;
    logic [WEXPSUM-1:0] w_texp;
    logic [WEXP-1:0]    w_rexp;
    logic               w_ovf;
    logic               w_still;
    logic               w_inx;
    logic               w_dnr;

    assign w_rovf  = r_s1_rd & r_s1_mp1[WSIG];
    assign w_prod  = r_s1_rd ? (w_rovf ? '0 : r_s1_mp1[WSIG-1:0])
                             : r_s1_msb;
    assign w_texp  = r_s1_exp + WEXPSUM'(w_rovf);
    assign w_rexp  = w_texp[WEXP-1:0];
    assign w_ovf   = (&w_texp[WEXP-1:0]) | (|w_texp[WEXPSUM-1:WEXP]);
    assign w_still = ~|w_rexp;
    assign w_inx   = r_s1_rd | r_s1_guard | r_s1_sticky;
    assign w_dnr   = r_s1_tiny & r_s1_rd & ~r_s1_dsticky & r_s1_guard;

    // Stage 2: register results, hold while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            roundprod   <= '0;
            roundexp    <= '0;
            inexact     <= 1'b0;
            overflow    <= 1'b0;
            stilltiny   <= 1'b0;
            denormround <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                roundprod   <= w_prod;
                roundexp    <= w_rexp;
                inexact     <= w_inx;
                overflow    <= w_ovf;
                stilltiny   <= w_still;
                denormround <= w_dnr;
            end
        end
    end

    // Flags of the result leaving this cycle
    logic [3:0] w_new_flags;

    always_comb begin
        w_new_flags          = '0;
        w_new_flags[FLG_OVF] = overflow;
        w_new_flags[FLG_UNF] = stilltiny & inexact;
        w_new_flags[FLG_INX] = inexact;
        w_new_flags[FLG_DNR] = denormround;
    end

    // Sticky flag accumulation; clear with handshake keeps only new flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_acc <= '0;
        end else if (w_hs_out) begin
            flags_acc <= (flag_clr ? 4'b0000 : flags_acc) | w_new_flags;
        end else if (flag_clr) begin
            flags_acc <= '0;
        end
    end

    logic w_unused;
    assign w_unused = w_hs_in;

endmodule

// File: doc/round_pipe.md
# round_pipe

Parametrised, pipelined successor to the floating-point multiplier's rounding stage. It accepts a normalised, shifted product and exponent, then applies IEEE rounding. Five rounding modes are supported, including round-to-nearest-ties-away. It produces the rounded significand and exponent plus exception flags through a two-stage valid/ready pipeline, and accumulates sticky exception flags across operations. It sits between the normaliser/shifter and the special-case/packing stage of the FP multiplier.

## Interface
- WSIG, 23: stored significand width.
- WEXP, 8: exponent field width.
- WEXPSUM, 10: width of the unbiased-sum exponent input; must be > WEXP.
- SHIFTWIDTH, 48: shifted product width; must be ≥ WSIG+3.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  stage 1 can accept.
- shiftprod  in  SHIFTWIDTH  normalised product; MSB is the bit below the hidden one.
- shiftexp  in  WEXPSUM  exponent after shift.
- shiftloss  in  1  bits lost during shifting.
- roundmode  in  3  000 RNE, 001 RZ, 010 RP, 011 RM, 100 RNA; 101–111 behave as RNE.
- sign  in  1  result sign.
- tiny  in  1  pre-round result denormal.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- roundprod  out  WSIG  rounded significand.
- roundexp  out  WEXP  rounded exponent.
- inexact, overflow, stilltiny, denormround  out  1 each  per-result flags.
- flag_clr  in  1  synchronous clear of accumulated flags.
- flags_acc  out  4  sticky {overflow, underflow, inexact, denormround}.

## Operation
- Field split:
  - MSBits = shiftprod[SW-1:SW-WSIG]
  - lsb = shiftprod[SW-WSIG]
  - guard = shiftprod[SW-WSIG-1]
  - sticky = |shiftprod[SW-WSIG-2:0] | shiftloss
  - denormsticky = |shiftprod[SW-WSIG-3:0] | shiftloss
- Round-up decision (rd):
  - RNE: guard & (lsb | sticky)
  - RNA: guard
  - RZ: 0
  - RP: ~sign & (guard | sticky)
  - RM: sign & (guard | sticky)
- MSBitsplus1 is WSIG+1 bits wide.
- roundoverflow = rd & MSBitsplus1[WSIG].
- roundprod = rd ? (roundoverflow ? 0 : MSBitsplus1[WSIG-1:0]) : MSBits.
- tempexp = shiftexp + roundoverflow, computed at WEXPSUM width.
- overflow = &tempexp[WEXP-1:0] | |tempexp[WEXPSUM-1:WEXP].
- roundexp = tempexp[WEXP-1:0].
- stilltiny = ~|roundexp.
- inexact = rd | guard | sticky.
- denormround = tiny & rd & ~denormsticky & guard.
- Flag accumulation:
  - On each output handshake (out_valid & out_ready), flags_acc |= {overflow, stilltiny & inexact, inexact, denormround}.
  - flag_clr alone zeroes flags_acc.
  - flag_clr coinciding with a handshake loads only that result's flags.

## Timing
- Stage 1 register: captures the field split, rd, MSBitsplus1, shiftexp, tiny and denormsticky on input handshake.
- Stage 2 register: captures the final outputs.
- Latency is 2 cycles from input handshake to out_valid; throughput is 1 op/cycle with no bubbles while out_ready=1.
- Stall and ready rules:
  - Stage 2 advances when ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s2_advance, combinational from registered state and out_ready.
- Outputs hold stable while out_valid & ~out_ready.
- Reset, asynchronous:
  - s1_valid, s2_valid, out_valid = 0.
  - All data and flag outputs = 0.
  - flags_acc = 0.
  - in_ready = 1 after reset.
- Reset mid-operation flushes both stages; in-flight results are discarded and never accumulated.

## Structure
- Package fm_round_pkg: roundmode encodings (RM_RNE, RM_RZ, RM_RP, RM_RM, RM_RNA) and flags_acc bit indices.
- Sub-module round_decide: purely combinational. It takes lsb, guard, sticky, sign and roundmode, and returns rd. It is instantiated in stage 1.

## Test plan
1. WSIG=23, RNE, MSBits=0x000001, guard=1, sticky=0 → roundprod=0x000002, inexact=1, roundexp=shiftexp.
2. RNE, MSBits=0x7FFFFF, guard=1, sticky=1, shiftexp=0x0FE → roundprod=0, roundexp=0xFF, overflow=1, flags_acc[3]=1.
3. Tie with even lsb (MSBits=0x000002, guard=1, sticky=0) in each mode:
   - RNE → 0x000002
   - RNA → 0x000003
   - RZ → 0x000002
   - RP with sign=0 → 0x000003
   - RM with sign=0 → 0x000002
4. tiny=1, shiftexp=0, RNE, guard=1, lsb=1, denormsticky=0 → denormround=1, stilltiny=1.
5. Back-to-back 4 ops with out_ready low for cycles 3–5 → no loss or duplication, in_ready=0 while both stages are full, results in order, latency 2 when unstalled.
6. Assert reset with 2 ops in flight → out_valid=0 immediately, flags_acc=0. flag_clr coinciding with an inexact handshake → flags_acc=0b0010.
